// File: rtl/cart_load_ctrl.sv
// Cartridge download controller: copies ioctl bytes into cartridge RAM, tracks the address
// mirror mask, and optionally issues a delayed reset pulse to skip the boot logo.
module cart_load_ctrl #(
   parameter int unsigned TIMEOUT   = 5000000,
   parameter int unsigned PULSE_LEN = 1000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ext_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        skip_logo,
   output logic        cart_wr,
   output logic [14:0] cart_addr,
   output logic [7:0]  cart_data,
   output logic [14:0] cart_mask,
   output logic        core_reset,
   output logic        overflow,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StSettle = 2'd2,
      StPulse  = 2'd3
   } state_e;

   // Largest value ever loaded is TIMEOUT-2, so $clog2(TIMEOUT) bits suffice.
   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] SettleLoad = CntW'(TIMEOUT - PULSE_LEN - 1);
   localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE_LEN - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            dl_q;
   logic [14:0]     mask_q, mask_d;
   logic            ovf_q, ovf_d;
   logic            wr_q, wr_d;
   logic [14:0]     addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic            dl_rise, dl_fall;

   assign dl_rise = ioctl_download & ~dl_q;
   assign dl_fall = ~ioctl_download & dl_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dl_q    <= 1'b0;
         mask_q  <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dl_q    <= ioctl_download;
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      ovf_d   = ovf_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;

      unique case (state_q)
         StIdle: ;
         StLoad: begin
            if (ioctl_wr) begin
               if (ioctl_addr[24:15] == '0) begin
                  wr_d   = 1'b1;
                  addr_d = ioctl_addr[14:0];
                  data_d = ioctl_dout;
                  // Mask grows by one bit per strobe that lands outside it; saturates at 0x7FFF.
                  if ((ioctl_addr[14:0] & ~mask_q) != '0) begin
                     mask_d = {mask_q[13:0], 1'b1};
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (dl_fall) begin
               if (skip_logo) begin
                  state_d = StSettle;
                  cnt_d   = SettleLoad;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StPulse;
               cnt_d   = PulseLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase

      // A new download always wins and abandons any pending countdown.
      if (dl_rise) begin
         state_d = StLoad;
         cnt_d   = '0;
         mask_d  = '0;
         ovf_d   = 1'b0;
      end
   end

   assign cart_wr    = wr_q;
   assign cart_addr  = addr_q;
   assign cart_data  = data_q;
   assign cart_mask  = mask_q;
   assign overflow   = ovf_q;
   assign state      = state_q;
   assign core_reset = reset | ext_reset | ioctl_download | (state_q == StPulse);

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Scoreboard bench for cart_load_ctrl: stimulus pushes expected cartridge writes, a negedge
// monitor pops and compares them; mask/overflow/state timeline come from a behavioural model.
module tb_cart_load_ctrl;

   localparam int unsigned TIMEOUT   = 20;
   localparam int unsigned PULSE_LEN = 4;

   logic        clk_sys = 1'b0;
   logic        reset, ext_reset, ioctl_download, ioctl_wr, skip_logo;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        cart_wr, core_reset, overflow;
   logic [14:0] cart_addr, cart_mask;
   logic [7:0]  cart_data;
   logic [1:0]  state;

   cart_load_ctrl #(.TIMEOUT(TIMEOUT), .PULSE_LEN(PULSE_LEN)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ext_reset      (ext_reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .skip_logo      (skip_logo),
      .cart_wr        (cart_wr),
      .cart_addr      (cart_addr),
      .cart_data      (cart_data),
      .cart_mask      (cart_mask),
      .core_reset     (core_reset),
      .overflow       (overflow),
      .state          (state)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int unsigned cyc;
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model of the download session.
   bit          m_load = 0;
   logic [14:0] m_mask = '0;
   bit          m_ovf = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk_sys) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL cart_wr_missing: got none expected write addr 0x%0h at cycle %0d",
                  mon_e.addr, mon_e.cyc);
      end
      if (cart_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL cart_wr_extra: got write addr 0x%0h at cycle %0d expected none",
                     cart_addr, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("cart_wr_cycle", cyc, mon_e.cyc);
            chk("cart_addr", {17'd0, cart_addr}, {17'd0, mon_e.addr});
            chk("cart_data", {24'd0, cart_data}, {24'd0, mon_e.data});
         end
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      wr_t e;
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (m_load) begin
         if (a[24:15] == 10'd0) begin
            e.cyc  = cyc + 1;
            e.addr = a[14:0];
            e.data = d;
            exp_q.push_back(e);
            if ((a[14:0] & ~m_mask) != 15'd0) m_mask = ((m_mask << 1) | 15'd1) & 15'h7fff;
         end else begin
            m_ovf = 1;
         end
      end
      step();
      ioctl_wr = 1'b0;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      step();
      m_load = 1;
      m_mask = '0;
      m_ovf  = 0;
      chk("enter_load_state", {30'd0, state}, 32'd1);
      chk("enter_load_mask", {17'd0, cart_mask}, 32'd0);
      chk("enter_load_ovf", {31'd0, overflow}, 32'd0);
   endtask

   // Ends the download; abort_at>0 raises a new download at that settle cycle.
   task automatic end_dl(input bit skip, input bit toggle_ext, input int abort_at);
      int bad;
      int unsigned exp_st;
      logic exp_cr;
      ioctl_download = 1'b0;
      skip_logo      = skip;
      step();
      m_load = 0;
      if (!skip) begin
         chk("noskip_idle", {30'd0, state}, 32'd0);
         bad = 0;
         for (int k = 0; k < int'(TIMEOUT) + 5; k++) begin
            if (state !== 2'd0 || core_reset !== 1'b0) bad++;
            step();
         end
         chk("noskip_no_pulse_cycles", bad, 0);
      end else begin
         for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
            if (k > 1) step();
            ext_reset = toggle_ext && (k >= 5) && (k <= 9) && (k % 2 == 1);
            #1;
            if (k <= int'(TIMEOUT - PULSE_LEN)) exp_st = 2;
            else if (k <= int'(TIMEOUT)) exp_st = 3;
            else exp_st = 0;
            exp_cr = (exp_st == 3) ? 1'b1 : ext_reset;
            chk($sformatf("skip_state_k%0d", k), {30'd0, state}, exp_st);
            chk($sformatf("skip_core_reset_k%0d", k), {31'd0, core_reset}, {31'd0, exp_cr});
            if (abort_at > 0 && k == abort_at) begin
               ioctl_download = 1'b1;
               step();
               m_load = 1;
               m_mask = '0;
               m_ovf  = 0;
               chk("abort_load_state", {30'd0, state}, 32'd1);
               chk("abort_mask", {17'd0, cart_mask}, 32'd0);
               bad = 0;
               for (int j = 0; j < 20; j++) begin
                  step();
                  if (state !== 2'd1) bad++;
               end
               chk("abort_no_old_pulse", bad, 0);
               break;
            end
         end
         ext_reset = 1'b0;
      end
      chk("held_mask", {17'd0, cart_mask}, {17'd0, m_mask});
      chk("held_ovf", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic rand_session();
      logic [24:0] a;
      start_dl();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0)
            a = (25'($urandom_range(1, 1023)) << 15) | 25'($urandom_range(0, 32767));
         else if ($urandom_range(0, 1) == 0)
            a = 25'($urandom_range(0, 255));
         else
            a = 25'($urandom_range(0, 32767));
         strobe(a, 8'($urandom));
         repeat ($urandom_range(0, 2)) step();
      end
      step();
      chk("rand_mask", {17'd0, cart_mask}, {17'd0, m_mask});
      chk("rand_ovf", {31'd0, overflow}, {31'd0, m_ovf});
      end_dl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
   endtask

   initial begin
      reset = 1'b1; ext_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; skip_logo = 1'b0;
      repeat (3) step();
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_cart_wr", {31'd0, cart_wr}, 32'd0);
      chk("rst_cart_addr", {17'd0, cart_addr}, 32'd0);
      chk("rst_cart_data", {24'd0, cart_data}, 32'd0);
      chk("rst_mask", {17'd0, cart_mask}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
      reset = 1'b0;
      step();
      chk("idle_core_reset", {31'd0, core_reset}, 32'd0);

      // Strobes outside LOAD must be ignored.
      strobe(25'h5, 8'h33);
      step();

      // Eight bytes at 0..7, then plain end of download.
      start_dl();
      for (int i = 0; i < 8; i++) strobe(25'(i), 8'(8'hA0 + i));
      step();
      chk("small_mask", {17'd0, cart_mask}, 32'h7);
      chk("small_ovf", {31'd0, overflow}, 32'd0);
      end_dl(1'b0, 1'b0, 0);

      // 8 KiB image, overflow strobe, then skip-logo pulse with ext_reset activity.
      start_dl();
      for (int i = 0; i < 32'h2000; i++) strobe(25'(i), 8'($urandom));
      step();
      chk("8k_mask", {17'd0, cart_mask}, 32'h1fff);
      strobe(25'h8000, 8'h55);
      step();
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_mask_unchanged", {17'd0, cart_mask}, 32'h1fff);
      end_dl(1'b1, 1'b1, 0);

      // New download during SETTLE abandons the pulse.
      start_dl();
      for (int i = 0; i < 4; i++) strobe(25'(i * 3), 8'(i));
      end_dl(1'b1, 1'b0, 5);
      strobe(25'h40, 8'h77);
      step();
      end_dl(1'b0, 1'b0, 0);

      // Reset in the middle of a download with ioctl_download held high.
      start_dl();
      for (int i = 0; i < 6; i++) strobe(25'(i + 16), 8'(i));
      step();
      reset = 1'b1;
      step();
      m_load = 0;
      chk("midrst_state", {30'd0, state}, 32'd0);
      chk("midrst_cart_wr", {31'd0, cart_wr}, 32'd0);
      chk("midrst_cart_addr", {17'd0, cart_addr}, 32'd0);
      chk("midrst_cart_data", {24'd0, cart_data}, 32'd0);
      chk("midrst_mask", {17'd0, cart_mask}, 32'd0);
      chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
      reset = 1'b0;
      step();
      m_load = 1;
      m_mask = '0;
      m_ovf  = 0;
      chk("postrst_load", {30'd0, state}, 32'd1);
      strobe(25'h10, 8'h99);
      strobe(25'h20, 8'h9a);
      step();
      chk("postrst_mask", {17'd0, cart_mask}, {17'd0, m_mask});
      end_dl(1'b1, 1'b0, 0);

      repeat (4) rand_session();

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
